// File: rtl/sisc_pkg.sv
// sisc_pkg: shared types and defaults for the SISC memory arbiter.
//   arb_state_t : arbiter state encoding (IDLE, ACCESS, RESP)
//   owner_t     : which requester holds the current access (OWN_IF, OWN_DM)
//   SISC_ADDR_W / SISC_DATA_W : default address and data widths
package sisc_pkg;

  localparam int SISC_ADDR_W = 16;
  localparam int SISC_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_streak.sv
// arb_streak: data-grant streak counter and winner selection for mem_arb.
// Data requests normally win, but after MAX_DM_STREAK consecutive data
// grants taken while fetch was waiting, fetch gets the next slot.
// Ports:
//   clk, rst_f        clock, asynchronous active-low reset
//   if_req, dm_req    current requests (only meaningful while the arbiter is idle)
//   grant             a grant is issued at this clock edge
//   grant_owner       requester receiving that grant
//   dm_wins           data side wins if a grant is issued now
module arb_streak
  import sisc_pkg::*;
#(
  parameter int MAX_DM_STREAK = 3
) (
  input  logic   clk,
  input  logic   rst_f,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   grant,
  input  owner_t grant_owner,
  output logic   dm_wins
);

  localparam int SW = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  logic [SW-1:0] streak;
  logic          at_limit;

  assign at_limit = (streak == STREAK_MAX);

  // Fetch only pre-empts data once the streak has reached its limit.
  assign dm_wins = dm_req && !(if_req && at_limit);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      streak <= '0;
    end else if (grant) begin
      if (grant_owner == OWN_DM && if_req) begin
        if (!at_limit) begin
          streak <= streak + 1'b1;
        end
      end else begin
        // Any fetch grant, or a data grant with nobody waiting, restarts the count.
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbiter sharing the single-ported SISC memory between
// instruction fetch (if_*) and data load/store (dm_*).
// Requests are sampled only in IDLE; the winner's address/we/wdata are
// latched, the access is held until mem_ready, and the owner then gets a
// one-cycle rvalid pulse. Throughput is at most one access per 3 cycles.
// Ports:
//   clk, rst_f                      clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata       fetch grant pulse, data-valid pulse, last fetched word
//   dm_req/dm_we/dm_addr/dm_wdata   data request (held until dm_gnt)
//   dm_gnt/dm_rvalid/dm_rdata       data grant pulse, completion pulse, last loaded word
//   mem_en/mem_we/mem_addr/mem_wdata  memory-side access controls (registered)
//   mem_rdata/mem_ready             memory read data and completion strobe
//   busy                            state is not IDLE
//   err                             timeout abort pulse
// Build option: define MEM_ARB_TIMEOUT_EN to abort an access after TIMEOUT
// ACCESS cycles without mem_ready (owner rvalid and err pulse together).
// Without it ACCESS waits indefinitely and err is constant 0.
module mem_arb
  import sisc_pkg::*;
#(
  parameter int ADDR_W        = SISC_ADDR_W,
  parameter int DATA_W        = SISC_DATA_W,
  parameter int MAX_DM_STREAK = 3,
  parameter int TIMEOUT       = 15
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);

  arb_state_t state;
  owner_t     owner;
  owner_t     next_owner;
  logic       any_req;
  logic       grant;
  logic       dm_wins;

  assign any_req    = if_req | dm_req;
  assign grant      = (state == IDLE) && any_req;
  assign next_owner = dm_wins ? OWN_DM : OWN_IF;
  assign busy       = (state != IDLE);

  arb_streak #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_streak (
    .clk        (clk),
    .rst_f      (rst_f),
    .if_req     (if_req),
    .dm_req     (dm_req),
    .grant      (grant),
    .grant_owner(next_owner),
    .dm_wins    (dm_wins)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timed_out;

  // wait_cnt holds the number of completed ACCESS cycles, so the abort
  // happens at the edge that ends the TIMEOUT-th cycle.
  assign timed_out = (wait_cnt == WAIT_LAST);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
      err       <= 1'b0;
`endif
    end else begin
      // Grants and completions are single-cycle pulses.
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= ACCESS;
            owner  <= next_owner;
            mem_en <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (dm_wins) begin
              dm_gnt    <= 1'b1;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              if_gnt    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            state  <= RESP;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner == OWN_IF) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end else begin
              dm_rvalid <= 1'b1;
              // Stores complete without disturbing the last load value.
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (timed_out) begin
            state  <= RESP;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            err    <= 1'b1;
            if (owner == OWN_IF) begin
              if_rvalid <= 1'b1;
            end else begin
              dm_rvalid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: self-checking bench for mem_arb.
// Directed vector table, hand-written multi-cycle sequences (continuous
// contention, reset during ACCESS, request during RESP, timeout) and a
// randomized run checked against a transaction-level reference model.
module tb_mem_arb;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int MAXS = 3;
  localparam int TO  = 15;

  logic          clk;
  logic          rst_f;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;
  logic          err;

  mem_arb #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state: last returned words and the data-grant streak.
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_dm_rdata;
  int            model_streak;

  typedef struct {
    bit            iq;
    bit            dq;
    bit            we;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [DW-1:0] wd;
    int            waits;
    logic [DW-1:0] rd;
    bit            exp_dm;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  function automatic vec_t mk(input bit iq, input bit dq, input bit we,
                              input logic [AW-1:0] ia, input logic [AW-1:0] da,
                              input logic [DW-1:0] wd, input int waits,
                              input logic [DW-1:0] rd, input bit exp_dm);
    vec_t v;
    v.iq = iq; v.dq = dq; v.we = we; v.ia = ia; v.da = da;
    v.wd = wd; v.waits = waits; v.rd = rd; v.exp_dm = exp_dm;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_f = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_f = 1'b1;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    model_streak = 0;
    cyc();
  endtask

  // One complete transaction. Entered in an IDLE cycle; returns in the
  // following IDLE cycle. The winner drops its request in its rvalid cycle,
  // the loser keeps requesting.
  task automatic do_round(input string tag, input bit iq, input bit dq, input bit we,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [DW-1:0] wd, input int waits,
                          input logic [DW-1:0] rd, input bit exp_dm);
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    exp_addr = exp_dm ? da : ia;
    exp_we   = exp_dm ? we : 1'b0;
    if_req = iq; if_addr = ia;
    dm_req = dq; dm_we = we; dm_addr = da; dm_wdata = wd;
    mem_ready = 1'b0;
    cyc();
    chk({tag, "_if_gnt"}, if_gnt, !exp_dm);
    chk({tag, "_dm_gnt"}, dm_gnt, exp_dm);
    chk({tag, "_mem_addr"}, mem_addr, exp_addr);
    chk({tag, "_mem_we"}, mem_we, exp_we);
    if (exp_dm && we) chk({tag, "_mem_wdata"}, mem_wdata, wd);
    for (int k = 0; k <= waits; k++) begin
      if (k > 0) begin
        cyc();
        chk({tag, "_gnt_pulse"}, {if_gnt, dm_gnt}, 2'b00);
        chk({tag, "_rvalid_early"}, {if_rvalid, dm_rvalid}, 2'b00);
      end
      chk({tag, "_mem_en"}, mem_en, 1'b1);
      chk({tag, "_busy_acc"}, busy, 1'b1);
      mem_ready = (k == waits);
      mem_rdata = (k == waits) ? rd : DW'($urandom);
    end
    cyc();
    mem_ready = 1'b0;
    mem_rdata = DW'($urandom);
    if (!exp_dm) exp_if_rdata = rd;
    else if (!we) exp_dm_rdata = rd;
    chk({tag, "_if_rvalid"}, if_rvalid, !exp_dm);
    chk({tag, "_dm_rvalid"}, dm_rvalid, exp_dm);
    chk({tag, "_mem_en_resp"}, mem_en, 1'b0);
    chk({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
    chk({tag, "_dm_rdata"}, dm_rdata, exp_dm_rdata);
    chk({tag, "_err"}, err, 1'b0);
    if (exp_dm) dm_req = 1'b0;
    else if_req = 1'b0;
    cyc();
    chk({tag, "_busy_idle"}, busy, 1'b0);
    chk({tag, "_rvalid_pulse"}, {if_rvalid, dm_rvalid}, 2'b00);
    $display("txn %s owner=%s addr=%h we=%0d waits=%0d rdata=%h",
             tag, exp_dm ? "dm" : "if", exp_addr, exp_we, waits, rd);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            pend_if, pend_dm, r_we, win_dm;
    logic [AW-1:0] r_ia, r_da;
    logic [DW-1:0] r_wd;
    int            n;
    bit            order[8];

    // ---------------- reset state ----------------
    rst_f = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pulses", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, err}, 5'b0);
    chk("reset_mem", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
    chk("reset_rdata", {if_rdata, dm_rdata}, '0);
    chk("reset_busy", busy, 1'b0);

    // ---------------- directed vector table ----------------
    vecs[0] = mk(1, 0, 0, 16'h0010, 16'h0000, 32'h0, 0, 32'h1234_5678, 0);
    vecs[1] = mk(0, 1, 1, 16'h0000, 16'h0040, 32'hCAFE_0001, 3, 32'hDEAD_BEEF, 1);
    vecs[2] = mk(0, 1, 0, 16'h0000, 16'h0044, 32'h0, 1, 32'hA5A5_0F0F, 1);
    vecs[3] = mk(1, 0, 0, 16'h0014, 16'h0000, 32'h0, 2, 32'h0BAD_F00D, 0);
    for (int i = 0; i < 8; i++) begin
      // Both held: dm,dm,dm,if repeating from a cleared streak.
      vecs[4 + i] = mk(1, 1, 0, 16'h0100, 16'h0200, 32'h0, i % 3,
                       32'h5000_0000 + DW'(i), (i % 4) != 3);
    end
    vecs[12] = mk(0, 1, 0, 16'h0000, 16'h0200, 32'h0, 0, 32'h7777_0012, 1);
    vecs[13] = mk(1, 1, 1, 16'h0500, 16'h0210, 32'h1111_0013, 1, 32'h8888_0013, 1);
    vecs[14] = mk(1, 1, 0, 16'h0500, 16'h0214, 32'h0, 2, 32'h9999_0014, 1);
    vecs[15] = mk(1, 0, 0, 16'h0500, 16'h0000, 32'h0, 0, 32'hAAAA_0015, 0);

    apply_reset();
    for (int i = 0; i < 16; i++) begin
      do_round($sformatf("vec%0d", i), vecs[i].iq, vecs[i].dq, vecs[i].we,
               vecs[i].ia, vecs[i].da, vecs[i].wd, vecs[i].waits,
               vecs[i].rd, vecs[i].exp_dm);
    end

    // ---------------- continuous contention ----------------
    apply_reset();
    if_req = 1'b1; if_addr = 16'h0300;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0400;
    mem_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      cyc();
      if (if_gnt || dm_gnt) begin
        chk("cont_gnt_exclusive", {if_gnt, dm_gnt} == 2'b11, 1'b0);
        order[n] = dm_gnt;
        n++;
      end
    end
    chk("cont_grant_count", n, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cont_order%0d", i), order[i], (i % 4) != 3);
    end
    $display("txn contention grants=%0d", n);

    // ---------------- reset during ACCESS ----------------
    apply_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0050;
    cyc();
    chk("rst_acc_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0;
    cyc();
    chk("rst_acc_en", mem_en, 1'b1);
    #2 rst_f = 1'b0;
    #1;
    chk("rst_acc_en_drop", mem_en, 1'b0);
    chk("rst_acc_busy_drop", busy, 1'b0);
    chk("rst_acc_pulses", {if_gnt, dm_gnt, if_rvalid, dm_rvalid}, 4'b0);
    @(negedge clk);
    rst_f = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_acc_no_rvalid", {if_rvalid, dm_rvalid}, 2'b00);
      chk("rst_acc_idle", {busy, mem_en}, 2'b00);
    end
    mem_ready = 1'b0;
    $display("txn reset_during_access");

    // ---------------- request arriving during RESP ----------------
    apply_reset();
    if_req = 1'b1; if_addr = 16'h0020; mem_ready = 1'b1;
    cyc();
    chk("resp_req_if_gnt", if_gnt, 1'b1);
    cyc();
    chk("resp_req_if_rvalid", if_rvalid, 1'b1);
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0060;
    cyc();
    chk("resp_req_no_gnt", dm_gnt, 1'b0);
    chk("resp_req_idle", busy, 1'b0);
    cyc();
    chk("resp_req_gnt_later", dm_gnt, 1'b1);
    chk("resp_req_addr", mem_addr, 16'h0060);
    dm_req = 1'b0;
    cyc();
    chk("resp_req_rvalid", dm_rvalid, 1'b1);
    mem_ready = 1'b0;
    $display("txn request_during_resp");

    // ---------------- stuck memory / timeout ----------------
    apply_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0070;
    cyc();
    chk("to_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    n = 0;
    while (mem_en && n < 40) begin
      chk("to_err_early", {err, dm_rvalid}, 2'b00);
      n++;
      cyc();
    end
    chk("to_en_cycles", n, TO);
    chk("to_rvalid", dm_rvalid, 1'b1);
    chk("to_err", err, 1'b1);
    chk("to_rdata_kept", dm_rdata, exp_dm_rdata);
    cyc();
    chk("to_pulse_end", {err, dm_rvalid}, 2'b00);
    $display("txn timeout en_cycles=%0d", n);
`else
    for (int i = 0; i < TO + 5; i++) begin
      chk("stall_en", mem_en, 1'b1);
      chk("stall_err", err, 1'b0);
      chk("stall_rvalid", dm_rvalid, 1'b0);
      cyc();
    end
    $display("txn stall_no_timeout");
`endif

    // ---------------- randomized run vs reference model ----------------
    apply_reset();
    pend_if = 0; pend_dm = 0;
    r_ia = '0; r_da = '0; r_we = 0; r_wd = '0;
    for (int t = 0; t < 40; t++) begin
      if (!pend_if && ($urandom_range(0, 1) == 1)) begin
        pend_if = 1; r_ia = AW'($urandom);
      end
      if (!pend_dm && ($urandom_range(0, 2) != 0)) begin
        pend_dm = 1; r_da = AW'($urandom); r_we = 1'($urandom);
        r_wd = DW'($urandom);
      end
      if (!pend_if && !pend_dm) begin
        pend_if = 1; r_ia = AW'($urandom);
      end
      // Data first, unless fetch has already waited out MAX data grants.
      win_dm = pend_dm && !(pend_if && model_streak >= MAXS);
      if (win_dm && pend_if) model_streak = (model_streak + 1 > MAXS) ? MAXS : model_streak + 1;
      else model_streak = 0;
      do_round($sformatf("rnd%0d", t), pend_if, pend_dm, r_we, r_ia, r_da, r_wd,
               $urandom_range(0, 3), DW'($urandom), win_dm);
      if (win_dm) pend_dm = 0;
      else pend_if = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbiter sharing the single-ported SISC memory between instruction fetch (driven by pc/ctrl) and data load/store (driven by ctrl in memory-reference instructions).
- Owns the memory handshake: selects a requester, holds the access until memory answers, then returns read data with a one-cycle valid pulse.
- Sits between ctrl/pc and the unified memory; replaces direct im addressing.

Parameters:
- ADDR_W, 16, address width (matches pc_out width).
- DATA_W, 32, data and instruction width.
- MAX_DM_STREAK, 3, consecutive data grants allowed while fetch is waiting.
- TIMEOUT, 15, ACCESS cycles before abort (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_f  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_gnt  out  1  fetch accepted, one-cycle pulse.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  DATA_W  fetched instruction; holds the last value.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data accepted, one-cycle pulse.
- dm_rvalid  out  1  data access complete (load or store), one-cycle pulse.
- dm_rdata  out  DATA_W  load data; holds the last value.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready is high.
- mem_ready  in  1  memory completes the access this cycle.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  timeout abort pulse; tied to 0 without the macro.

Behaviour:
- Reset (rst_f low, async): state IDLE, all outputs 0, latches and streak counter 0. Reset during ACCESS aborts immediately: mem_en drops and no rvalid is issued.
- States and transitions:
  - IDLE: requests sampled only here. Any req at a clock edge moves to ACCESS and latches addr/we/wdata/owner.
  - ACCESS: mem_en = 1, mem_we = latched we. If mem_ready is high, capture mem_rdata (on loads and fetches) and move to RESP at that edge; otherwise stay.
  - RESP: owner's rvalid = 1 for exactly one cycle; return to IDLE.
- gnt timing: the owner's gnt is high during the first ACCESS cycle only.
- Requester obligation: drop req by its rvalid cycle. A req still high in IDLE is treated as a new request.
- Minimum latency: req sampled at edge N; gnt in cycle N; with mem_ready high in that cycle, rvalid in cycle N+1. Throughput is at most one access per 3 cycles.
- Stores: dm_rvalid still pulses; dm_rdata is unchanged.
- Priority when both reqs are high in IDLE: dm wins unless streak == MAX_DM_STREAK, in which case if wins.
- Streak counter:
  - increments on a dm grant while if_req is also high;
  - clears on any if grant, or on a dm grant with if_req low;
  - saturates at MAX_DM_STREAK.
- Requests arriving outside IDLE are ignored until IDLE; no queueing.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - a wait counter runs in ACCESS;
  - after TIMEOUT cycles with no mem_ready, mem_en drops and the block moves to RESP;
  - owner's rvalid and err pulse together for one cycle; rdata is unchanged.
- Undefined: ACCESS waits indefinitely; err is constant 0.

Decomposition:
- sisc_pkg: arb state typedef (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10), owner encoding (OWN_IF=0, OWN_DM=1), ADDR_W/DATA_W defaults.
- One sub-module, arb_streak: the streak counter plus the winner-select logic. Outputs dm_wins given if_req, dm_req and grant events.

Test Plan:
- Fetch only: if_addr=16'h0010, mem_ready tied 1, mem_rdata=32'h1234_5678 -> if_gnt in cycle N, if_rvalid in N+1, if_rdata=32'h1234_5678, busy high 2 cycles.
- Store with 3 wait states: dm_we=1, dm_addr=16'h0040, dm_wdata=32'hCAFE_0001 -> mem_en high 4 cycles, mem_we=1, dm_rvalid one cycle after mem_ready, dm_rdata unchanged.
- Contention: if_req and dm_req held high continuously with MAX_DM_STREAK=3 -> grant order dm,dm,dm,if, repeating.
- Reset asserted during ACCESS (2nd wait cycle) -> mem_en, busy, gnt and rvalid go 0 immediately; no rvalid after rst_f releases; state IDLE.
- Timeout (macro defined, TIMEOUT=15, mem_ready held 0) -> mem_en high 15 cycles, then dm_rvalid=1 and err=1 for one cycle; without the macro, mem_en stays high and err stays 0.
- req arriving during RESP -> not granted until the following IDLE cycle; gnt one cycle later.
